// File: rtl/lucas_lehmer_ctrl_if.sv
// Host-side bundle of the Lucas-Lehmer sequencer: request, abort and result signals.
// The squarer datapath stays on plain ports of the controller.
interface lucas_lehmer_ctrl_if #(
    parameter int BITWIDTH = 32
);
    logic                start;
    logic [7:0]          p_in;
    logic                abort;
    logic                busy;
    logic                done;
    logic                is_prime;
    logic                bad_p;
    logic [BITWIDTH-1:0] residue;
    logic [7:0]          iter;

    modport master (
        output start,
        output p_in,
        output abort,
        input  busy,
        input  done,
        input  is_prime,
        input  bad_p,
        input  residue,
        input  iter
    );

    modport slave (
        input  start,
        input  p_in,
        input  abort,
        output busy,
        output done,
        output is_prime,
        output bad_p,
        output residue,
        output iter
    );
endinterface

// File: rtl/lucas_lehmer_ctrl.sv
// Lucas-Lehmer test sequencer for M = 2^p - 1: drives an external squarer,
// folds each product mod M, subtracts 2 and reports the verdict and residue.
module lucas_lehmer_ctrl #(
    parameter int BITWIDTH   = 32,
    parameter int SQ_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    lucas_lehmer_ctrl_if.slave    host,
    output logic [BITWIDTH-1:0]   sq_x,
    input  logic [2*BITWIDTH-1:0] sq_y
);
    localparam int RW    = 2 * BITWIDTH;
    localparam int CNT_W = $clog2(SQ_LATENCY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FOLD1 = 3'd3;
    localparam logic [2:0] S_FOLD2 = 3'd4;
    localparam logic [2:0] S_FIX   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [CNT_W-1:0]    LAT     = CNT_W'(SQ_LATENCY);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [BITWIDTH-1:0] ZERO    = BITWIDTH'(0);
    localparam logic [BITWIDTH-1:0] TWO     = BITWIDTH'(2);
    localparam logic [BITWIDTH-1:0] FOUR    = BITWIDTH'(4);
    localparam logic [7:0]          P_MIN   = 8'd3;
    localparam logic [7:0]          P_MAX   = 8'(BITWIDTH);

    // 2^p - 1 built one bit wider so p == BITWIDTH does not overflow.
    function automatic logic [BITWIDTH-1:0] mersenne(input logic [7:0] p);
        logic [BITWIDTH:0] one_sh;
        one_sh = (BITWIDTH + 1)'(1) << p;
        return BITWIDTH'(one_sh - (BITWIDTH + 1)'(1));
    endfunction

    logic [2:0]          state_q, state_d;
    logic [7:0]          p_q, p_d;
    logic [BITWIDTH-1:0] m_q, m_d;
    logic [BITWIDTH-1:0] s_q, s_d;
    logic [RW-1:0]       r_q, r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          iter_q, iter_d;
    logic [BITWIDTH-1:0] sq_x_q, sq_x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                is_prime_q, is_prime_d;
    logic                bad_p_q, bad_p_d;
    logic [BITWIDTH-1:0] residue_q, residue_d;

    logic [RW-1:0]       m_wide_s;
    logic [RW-1:0]       fold_s;
    logic [RW-1:0]       t_s;
    logic [BITWIDTH-1:0] t_lo_s;
    logic [BITWIDTH-1:0] s_next_s;
    logic                p_ok_s;
    logic                last_s;
    logic                running_s;

    // Datapath helpers for the fold, the final reduction and the loop exit test.
    always_comb begin
        m_wide_s  = {{BITWIDTH{1'b0}}, m_q};
        fold_s    = (r_q & m_wide_s) + (r_q >> p_q);
        t_s       = (r_q >= m_wide_s) ? (r_q - m_wide_s) : r_q;
        t_lo_s    = t_s[BITWIDTH-1:0];
        // t < 2 only happens for t in {0,1}; (M - 2) + t then stays below M.
        s_next_s  = (t_lo_s >= TWO) ? (t_lo_s - TWO) : ((m_q - TWO) + t_lo_s);
        p_ok_s    = (host.p_in >= P_MIN) && (host.p_in <= P_MAX);
        last_s    = ((iter_q + 8'd1) == (p_q - 8'd2));
        running_s = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                    (state_q == S_FOLD1) || (state_q == S_FOLD2) ||
                    (state_q == S_FIX);
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        m_d        = m_q;
        s_d        = s_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        iter_d     = iter_q;
        sq_x_d     = sq_x_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        is_prime_d = is_prime_q;
        bad_p_d    = bad_p_q;
        residue_d  = residue_q;

        if (host.abort && running_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.start) begin
                        p_d        = host.p_in;
                        m_d        = mersenne(host.p_in);
                        s_d        = FOUR;
                        iter_d     = 8'd0;
                        is_prime_d = 1'b0;
                        residue_d  = ZERO;
                        if (p_ok_s) begin
                            bad_p_d = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            // Rejected runs still report the untouched seed as residue.
                            bad_p_d   = 1'b1;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            residue_d = FOUR;
                            state_d   = S_DONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    sq_x_d  = s_q;
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        r_d     = sq_y;
                        state_d = S_FOLD1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_FOLD1: begin
                    r_d     = fold_s;
                    state_d = S_FOLD2;
                end
                S_FOLD2: begin
                    r_d     = fold_s;
                    state_d = S_FIX;
                end
                S_FIX: begin
                    s_d    = s_next_s;
                    iter_d = iter_q + 8'd1;
                    if (last_s) begin
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        residue_d  = s_next_s;
                        is_prime_d = (s_next_s == ZERO) && !bad_p_q;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; synchronous reset overrides every input.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            p_q        <= 8'd0;
            m_q        <= ZERO;
            s_q        <= ZERO;
            r_q        <= {RW{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            iter_q     <= 8'd0;
            sq_x_q     <= ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            is_prime_q <= 1'b0;
            bad_p_q    <= 1'b0;
            residue_q  <= ZERO;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            m_q        <= m_d;
            s_q        <= s_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            iter_q     <= iter_d;
            sq_x_q     <= sq_x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            is_prime_q <= is_prime_d;
            bad_p_q    <= bad_p_d;
            residue_q  <= residue_d;
        end
    end

    assign sq_x          = sq_x_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.is_prime = is_prime_q;
    assign host.bad_p    = bad_p_q;
    assign host.residue  = residue_q;
    assign host.iter     = iter_q;
endmodule

// File: tb/tb_lucas_lehmer_ctrl.sv
// Directed bench for lucas_lehmer_ctrl: two instances (squarer latency 1 and 3)
// driven with hand-computed Lucas-Lehmer runs.
module tb_lucas_lehmer_ctrl;
    localparam int BW = 32;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    lucas_lehmer_ctrl_if #(.BITWIDTH(BW)) h0 ();
    lucas_lehmer_ctrl_if #(.BITWIDTH(BW)) h1 ();

    logic [BW-1:0]   sq_x0, sq_x1;
    logic [2*BW-1:0] sq_y0, sq_y1, pipe_a, pipe_b;
    logic            start_r, abort_r;
    logic [7:0]      p_r;
    int              sel;

    assign h0.start = start_r && (sel == 0);
    assign h1.start = start_r && (sel == 1);
    assign h0.abort = abort_r && (sel == 0);
    assign h1.abort = abort_r && (sel == 1);
    assign h0.p_in  = p_r;
    assign h1.p_in  = p_r;

    lucas_lehmer_ctrl #(.BITWIDTH(BW), .SQ_LATENCY(1)) dut0 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .host    (h0),
        .sq_x    (sq_x0),
        .sq_y    (sq_y0)
    );

    lucas_lehmer_ctrl #(.BITWIDTH(BW), .SQ_LATENCY(3)) dut1 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .host    (h1),
        .sq_x    (sq_x1),
        .sq_y    (sq_y1)
    );

    // Squarer models: combinational for latency 1, two extra stages for latency 3.
    assign sq_y0 = {{BW{1'b0}}, sq_x0} * {{BW{1'b0}}, sq_x0};
    always_ff @(posedge sys_clk) begin
        pipe_a <= {{BW{1'b0}}, sq_x1} * {{BW{1'b0}}, sq_x1};
        pipe_b <= pipe_a;
    end
    assign sq_y1 = pipe_b;

    logic          o_busy, o_done, o_is_prime, o_bad_p;
    logic [BW-1:0] o_residue, o_sq_x;
    logic [7:0]    o_iter;

    always_comb begin
        if (sel == 0) begin
            o_busy = h0.busy; o_done = h0.done; o_is_prime = h0.is_prime;
            o_bad_p = h0.bad_p; o_residue = h0.residue; o_iter = h0.iter; o_sq_x = sq_x0;
        end else begin
            o_busy = h1.busy; o_done = h1.done; o_is_prime = h1.is_prime;
            o_bad_p = h1.bad_p; o_residue = h1.residue; o_iter = h1.iter; o_sq_x = sq_x1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    int            done_cyc, busy0, done_after, busy_after, busy_post_abort;
    logic [BW-1:0] sq_log[$];
    logic [BW-1:0] last_sq;

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; start_r = 1'b0; abort_r = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // done_cyc is the cycle number counted with the start edge as cycle 0 boundary
    // (done seen right after edge k is cycle k+1); -1 if never seen within budget.
    task automatic run_p(input int which, input logic [7:0] p, input int start_len,
                         input logic abort_with_start, input int restart_at,
                         input int abort_at, input int budget);
        int cyc;
        sel = which;
        sq_log.delete();
        done_cyc = -1; busy_post_abort = -1; done_after = -1; busy_after = -1;
        @(negedge sys_clk);
        last_sq = o_sq_x;
        p_r = p; start_r = 1'b1; abort_r = abort_with_start;
        @(posedge sys_clk); #1;
        cyc = 0;
        busy0 = int'(o_busy);
        while (done_cyc < 0 && cyc <= budget) begin
            if (o_sq_x != last_sq) begin
                sq_log.push_back(o_sq_x);
                last_sq = o_sq_x;
            end
            if (cyc == abort_at + 1) busy_post_abort = int'(o_busy);
            if (o_done) begin
                done_cyc = cyc + 1;
            end else begin
                start_r = (cyc + 1 < start_len) || (cyc == restart_at);
                p_r     = (cyc == restart_at) ? 8'd7 : p;
                abort_r = (cyc == abort_at);
                @(posedge sys_clk); #1;
                cyc++;
            end
        end
        start_r = 1'b0; abort_r = 1'b0;
        if (done_cyc > 0) begin
            @(posedge sys_clk); #1;
            done_after = int'(o_done);
            busy_after = int'(o_busy);
        end
    endtask

    logic [BW-1:0] exp7 [5];

    initial begin
        exp7[0] = 32'd4; exp7[1] = 32'd14; exp7[2] = 32'd67; exp7[3] = 32'd42; exp7[4] = 32'd111;
        sys_rst = 1'b1; start_r = 1'b0; abort_r = 1'b0; p_r = 8'd0; sel = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_done", 64'(o_done), 64'd0);
        check_eq("rst_prime", 64'(o_is_prime), 64'd0);
        check_eq("rst_bad_p", 64'(o_bad_p), 64'd0);
        check_eq("rst_residue", 64'(o_residue), 64'd0);
        check_eq("rst_iter", 64'(o_iter), 64'd0);
        check_eq("rst_sq_x", 64'(o_sq_x), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // p=11, reset while waiting on the squarer in the 4th iteration.
        @(negedge sys_clk);
        p_r = 8'd11; start_r = 1'b1;
        @(posedge sys_clk); #1;
        start_r = 1'b0;
        repeat (17) @(posedge sys_clk);
        #1;
        check_eq("mid_sq_x", 64'(o_sq_x), 64'd788);
        check_eq("mid_iter", 64'(o_iter), 64'd3);
        check_eq("mid_busy", 64'(o_busy), 64'd1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check_eq("mrst_busy", 64'(o_busy), 64'd0);
        check_eq("mrst_sq_x", 64'(o_sq_x), 64'd0);
        check_eq("mrst_iter", 64'(o_iter), 64'd0);
        check_eq("mrst_done", 64'(o_done), 64'd0);

        // p=3 with abort in the same IDLE cycle as start: start wins.
        run_p(0, 8'd3, 1, 1'b1, -1, -1, 300);
        check_eq("p3_done_cyc", 64'(done_cyc), 64'd6);
        check_eq("p3_busy0", 64'(busy0), 64'd1);
        check_eq("p3_prime", 64'(o_is_prime), 64'd1);
        check_eq("p3_residue", 64'(o_residue), 64'd0);
        check_eq("p3_iter", 64'(o_iter), 64'd1);
        check_eq("p3_sq_n", 64'(sq_log.size()), 64'd1);
        check_eq("p3_sq_x", 64'(o_sq_x), 64'd4);
        check_eq("p3_done_pulse", 64'(done_after), 64'd0);
        check_eq("p3_busy_after", 64'(busy_after), 64'd0);

        apply_reset();
        run_p(0, 8'd7, 1, 1'b0, -1, -1, 300);
        check_eq("p7_done_cyc", 64'(done_cyc), 64'd26);
        check_eq("p7_sq_n", 64'(sq_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("p7_sqx%0d", i),
                     64'((i < sq_log.size()) ? sq_log[i] : 32'hFFFF_FFFF), 64'(exp7[i]));
        check_eq("p7_prime", 64'(o_is_prime), 64'd1);
        check_eq("p7_residue", 64'(o_residue), 64'd0);
        check_eq("p7_iter", 64'(o_iter), 64'd5);

        run_p(0, 8'd11, 1, 1'b0, -1, -1, 300);
        check_eq("p11_done_cyc", 64'(done_cyc), 64'd46);
        check_eq("p11_prime", 64'(o_is_prime), 64'd0);
        check_eq("p11_residue", 64'(o_residue), 64'd1736);
        check_eq("p11_iter", 64'(o_iter), 64'd9);
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("p11_hold", 64'(o_residue), 64'd1736);

        // p=2 with start held into the DONE cycle: the second edge is ignored.
        run_p(0, 8'd2, 2, 1'b0, -1, -1, 300);
        check_eq("p2_done_cyc", 64'(done_cyc), 64'd1);
        check_eq("p2_bad_p", 64'(o_bad_p), 64'd1);
        check_eq("p2_prime", 64'(o_is_prime), 64'd0);
        check_eq("p2_sq_n", 64'(sq_log.size()), 64'd0);
        check_eq("p2_busy0", 64'(busy0), 64'd0);
        check_eq("p2_done_after", 64'(done_after), 64'd0);
        check_eq("p2_busy_after", 64'(busy_after), 64'd0);

        run_p(0, 8'd33, 1, 1'b0, -1, -1, 300);
        check_eq("p33_done_cyc", 64'(done_cyc), 64'd1);
        check_eq("p33_bad_p", 64'(o_bad_p), 64'd1);
        check_eq("p33_prime", 64'(o_is_prime), 64'd0);
        check_eq("p33_sq_n", 64'(sq_log.size()), 64'd0);

        // p=31 with a second start (p=7) while busy: must be ignored.
        run_p(0, 8'd31, 1, 1'b0, 20, -1, 300);
        check_eq("p31_done_cyc", 64'(done_cyc), 64'd146);
        check_eq("p31_prime", 64'(o_is_prime), 64'd1);
        check_eq("p31_bad_p", 64'(o_bad_p), 64'd0);
        check_eq("p31_residue", 64'(o_residue), 64'd0);
        check_eq("p31_iter", 64'(o_iter), 64'd29);

        // p=31 aborted during the 11th iteration.
        run_p(0, 8'd31, 1, 1'b0, -1, 53, 200);
        check_eq("abort_busy0", 64'(busy0), 64'd1);
        check_eq("abort_busy", 64'(busy_post_abort), 64'd0);
        check_eq("abort_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("abort_iter", 64'(o_iter), 64'd10);
        check_eq("abort_prime", 64'(o_is_prime), 64'd0);
        check_eq("abort_residue", 64'(o_residue), 64'd0);

        // Squarer latency 3 instance.
        apply_reset();
        run_p(1, 8'd31, 1, 1'b0, -1, -1, 300);
        check_eq("l3_p31_done_cyc", 64'(done_cyc), 64'd204);
        check_eq("l3_p31_prime", 64'(o_is_prime), 64'd1);
        check_eq("l3_p31_iter", 64'(o_iter), 64'd29);
        run_p(1, 8'd11, 1, 1'b0, -1, -1, 300);
        check_eq("l3_p11_done_cyc", 64'(done_cyc), 64'd64);
        check_eq("l3_p11_residue", 64'(o_residue), 64'd1736);
        check_eq("l3_p11_prime", 64'(o_is_prime), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
